serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor_pkg.sv | 12 +
 rtl/full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 95 +++++++++
 tb/tb_serial_subtractor.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package serial_subtractor_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = x - y - bin, with borrow out.
module full_subtractor (
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic d,
   output logic bo
);

   assign d  = x ^ y ^ bin;
   assign bo = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one bit per clock; result valid on the done pulse.
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic             borrow;
   logic [CW-1:0]    cnt;
   logic             d_bit;
   logic             bo_bit;

   full_subtractor u_fs (
      .x   (a_sh[0]),
      .y   (b_sh[0]),
      .bin (borrow),
      .d   (d_bit),
      .bo  (bo_bit)
   );

   // NOTE: all state here uses non-blocking assignments so every register sees
   // pre-edge values of the others; blocking would chain the shift within one edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         busy   <= 1'b0;
         done   <= 1'b0;
         diff   <= '0;
         bout   <= 1'b0;
         ovf    <= 1'b0;
         borrow <= 1'b0;
         cnt    <= '0;
         a_sh   <= '0;
         b_sh   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_sh   <= a;
                  b_sh   <= b;
                  borrow <= 1'b0;
                  cnt    <= '0;
                  diff   <= '0;
                  bout   <= 1'b0;
                  ovf    <= 1'b0;
                  busy   <= 1'b1;
                  state  <= RUN;
               end
            end
            RUN: begin
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               borrow <= bo_bit;
               diff   <= {d_bit, diff[WIDTH-1:1]};
               cnt    <= cnt + CW'(1);
               // On the last bit the operand MSBs sit at position 0, giving the sign terms.
               if (cnt == LAST_BIT) begin
                  bout  <= bo_bit;
                  ovf   <= (a_sh[0] ^ b_sh[0]) & (d_bit ^ a_sh[0]);
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): cycle model plus directed vectors.
module tb_serial_subtractor;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         bout;
   logic         ovf;

   int n_checks = 0;
   int n_fail   = 0;
   bit mon_en   = 1'b0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .diff  (diff),
      .bout  (bout),
      .ovf   (ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural model: plain integer subtraction on captured operands, timed by a bit countdown.
   logic         m_busy, m_done, m_bout, m_ovf;
   logic [W-1:0] m_diff, cap_a, cap_b;
   int           left;

   function automatic int to_signed(input logic [W-1:0] v);
      return v[W-1] ? int'(v) - (1 << W) : int'(v);
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         m_busy = 1'b0; m_done = 1'b0; m_diff = '0; m_bout = 1'b0; m_ovf = 1'b0; left = 0;
      end else if (m_done) begin
         m_done = 1'b0;
      end else if (m_busy) begin
         left--;
         if (left == 0) begin
            int sd;
            sd     = to_signed(cap_a) - to_signed(cap_b);
            m_busy = 1'b0;
            m_done = 1'b1;
            m_diff = W'(int'(cap_a) - int'(cap_b));
            m_bout = (cap_a < cap_b);
            m_ovf  = (sd > (1 << (W - 1)) - 1) || (sd < -(1 << (W - 1)));
         end
      end else if (start) begin
         cap_a = a; cap_b = b;
         m_busy = 1'b1; left = W;
         m_diff = '0; m_bout = 1'b0; m_ovf = 1'b0;
      end
   end

   // Compare DUT against the model every cycle; diff/flags are only meaningful outside RUN.
   always @(negedge clk) begin
      if (mon_en) begin
         check("mdl_busy", 32'(busy), 32'(m_busy));
         check("mdl_done", 32'(done), 32'(m_done));
         if (!m_busy) begin
            check("mdl_diff", 32'(diff), 32'(m_diff));
            check("mdl_bout", 32'(bout), 32'(m_bout));
            check("mdl_ovf",  32'(ovf),  32'(m_ovf));
         end
      end
   end

   // Pulse start, count edges to done and busy cycles, then check literal results.
   task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic [W-1:0] ed, input logic eb, input logic eo);
      int edges;
      int busy_cnt;
      edges = 0; busy_cnt = 0;
      start = 1'b1; a = ia; b = ib;
      do begin
         @(negedge clk);
         edges++;
         start = 1'b0;
         if (busy) busy_cnt++;
      end while (!done && edges < 30);
      check("latency", 32'(edges), 32'd9);
      check("busy_cycles", 32'(busy_cnt), 32'd8);
      check("diff", 32'(diff), 32'(ed));
      check("bout", 32'(bout), 32'(eb));
      check("ovf", 32'(ovf), 32'(eo));
      @(negedge clk);
      check("done_width", 32'(done), 32'd0);
   endtask

   initial begin
      int edges;
      rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
      @(negedge clk);
      @(negedge clk);
      mon_en = 1'b1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_diff", 32'(diff), 32'd0);
      check("rst_flags", 32'({bout, ovf}), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      run_op(8'h35, 8'h12, 8'h23, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      check("idle_hold", 32'(diff), 32'h23);
      run_op(8'h12, 8'h35, 8'hDD, 1'b1, 1'b0);
      run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
      run_op(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);
      run_op(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
      run_op(8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0);

      // start held high; operands change mid-run and must not leak into the first result
      start = 1'b1; a = 8'h35; b = 8'h12;
      @(negedge clk);
      repeat (2) @(negedge clk);
      a = 8'hFF; b = 8'h01;
      edges = 0;
      while (!done && edges < 30) begin @(negedge clk); edges++; end
      check("hold_first_diff", 32'(diff), 32'h23);
      @(negedge clk);
      check("hold_done_fall", 32'({done, busy}), 32'b00);
      @(negedge clk);
      check("hold_restart", 32'({done, busy}), 32'b01);
      edges = 0;
      while (!done && edges < 30) begin @(negedge clk); edges++; end
      check("hold_second_diff", 32'(diff), 32'hFE);
      check("hold_second_flags", 32'({bout, ovf}), 32'b00);
      start = 1'b0;
      @(negedge clk);
      check("hold_done_width", 32'(done), 32'd0);
      repeat (2) @(negedge clk);

      // reset in the middle of RUN aborts with no done pulse
      start = 1'b1; a = 8'h35; b = 8'h12;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_diff", 32'(diff), 32'd0);
      edges = 0;
      repeat (12) begin @(negedge clk); if (done) edges++; end
      check("abort_no_done", 32'(edges), 32'd0);
      run_op(8'h10, 8'h01, 8'h0F, 1'b0, 1'b0);

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
